// File: rtl/sblk_act_feeder.sv
// Activation feeder: answers sblk act_in_req pulses by streaming one batch of
// n_tn*n_tp*N_TILE words from activation memory, queueing requests that arrive mid-burst.
module sblk_act_feeder #(
  parameter int N_TILE      = 4,
  parameter int WID_ACT     = 16,
  parameter int WID_INST_TN = 4,
  parameter int WID_INST_TP = 5,
  parameter int WID_MEMADDR = 12,
  parameter int MEM_RD_LAT  = 2,
  parameter int MAX_PEND    = 3
) (
  input  logic                                       clk_l,
  input  logic                                       rst_n,
  input  logic                                       inst_en,
  input  logic [WID_INST_TN+WID_INST_TP+WID_MEMADDR-1:0] inst_data,
  input  logic                                       act_in_req,
  output logic                                       act_in_vld,
  output logic [2*WID_ACT-1:0]                       act_in,
  output logic                                       mem_rd_en,
  output logic [WID_MEMADDR-1:0]                     mem_rd_addr,
  input  logic [2*WID_ACT-1:0]                       mem_rd_data,
  output logic                                       busy,
  output logic                                       batch_done,
  output logic [1:0]                                 err
);

  localparam int TL_W   = WID_INST_TN + WID_INST_TP;
  localparam int BLEN_W = TL_W + $clog2(N_TILE);
  localparam int TILE_W = (N_TILE > 1) ? $clog2(N_TILE) : 1;
  localparam int PEND_W = $clog2(MAX_PEND + 1);
  localparam int DCNT_W = $clog2(MEM_RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                  state;
  logic [WID_INST_TN-1:0]  n_tn;
  logic [WID_INST_TP-1:0]  n_tp;
  logic [WID_MEMADDR-1:0]  base_addr;
  logic [TL_W-1:0]         trip_len;
  logic [BLEN_W-1:0]       blen;
  logic                    inst_hold;
  logic [PEND_W-1:0]       pend;
  logic [WID_MEMADDR-1:0]  cursor;
  logic [TL_W-1:0]         trip;
  logic [TILE_W-1:0]       tile;
  logic [DCNT_W-1:0]       drain_cnt;
  logic [MEM_RD_LAT:1]     en_sr;
  logic [MEM_RD_LAT:0]     en_tap;

  logic avail;
  logic drain_last;
  logic start;
  logic last_read;

  always_comb begin
    avail      = (pend != '0) || act_in_req;
    drain_last = (drain_cnt == DCNT_W'(MEM_RD_LAT));
    // A zero-length request in IDLE also counts as a start: it consumes a queue entry.
    start      = ((state == IDLE) && !inst_en && !inst_hold && avail) ||
                 ((state == DRAIN) && drain_last && avail);
    last_read  = (tile == TILE_W'(N_TILE - 1)) && (trip == trip_len - 1'b1);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      n_tn        <= '0;
      n_tp        <= '0;
      base_addr   <= '0;
      trip_len    <= '0;
      blen        <= '0;
      inst_hold   <= 1'b0;
      pend        <= '0;
      cursor      <= '0;
      trip        <= '0;
      tile        <= '0;
      drain_cnt   <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      batch_done  <= 1'b0;
      err         <= '0;
    end else begin
      batch_done <= 1'b0;
      inst_hold  <= 1'b0;
      trip_len   <= TL_W'(n_tn) * TL_W'(n_tp);
      blen       <= BLEN_W'(n_tn) * BLEN_W'(n_tp) * BLEN_W'(N_TILE);

      if (inst_en && (state == IDLE)) begin
        pend <= '0;
      end else if (act_in_req && !start) begin
        if (pend == PEND_W'(MAX_PEND)) err[0] <= 1'b1;
        else                           pend   <= pend + 1'b1;
      end else if (!act_in_req && start) begin
        pend <= pend - 1'b1;
      end

      if (inst_en && (state != IDLE)) err[1] <= 1'b1;

      case (state)
        IDLE: begin
          if (inst_en) begin
            n_tn      <= inst_data[WID_INST_TN-1:0];
            n_tp      <= inst_data[TL_W-1:WID_INST_TN];
            base_addr <= inst_data[TL_W+WID_MEMADDR-1:TL_W];
            cursor    <= '0;
            inst_hold <= 1'b1;
          end else if (start) begin
            if (blen != '0) begin
              state       <= STREAM;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= base_addr + cursor;
              cursor      <= cursor + 1'b1;
              trip        <= '0;
              tile        <= '0;
            end else begin
              batch_done <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (last_read) begin
            state      <= DRAIN;
            mem_rd_en  <= 1'b0;
            drain_cnt  <= DCNT_W'(1);
            batch_done <= (MEM_RD_LAT == 1);
          end else begin
            if (trip == trip_len - 1'b1) begin
              trip <= '0;
              tile <= tile + 1'b1;
            end else begin
              trip <= trip + 1'b1;
            end
            mem_rd_addr <= base_addr + cursor;
            cursor      <= cursor + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_last) begin
            if (start) begin
              state       <= STREAM;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= base_addr + cursor;
              cursor      <= cursor + 1'b1;
              trip        <= '0;
              tile        <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            drain_cnt  <= drain_cnt + 1'b1;
            batch_done <= ((drain_cnt + 1'b1) == DCNT_W'(MEM_RD_LAT));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tap k is mem_rd_en delayed k cycles; data is captured one stage before vld so both line up.
  assign en_tap     = {en_sr, mem_rd_en};
  assign act_in_vld = en_sr[MEM_RD_LAT];

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      en_sr  <= '0;
      act_in <= '0;
    end else begin
      en_sr <= en_tap[MEM_RD_LAT-1:0];
      if (en_tap[MEM_RD_LAT-1]) act_in <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_sblk_act_feeder.sv
// Directed bench for sblk_act_feeder: scoreboard of expected words per request,
// compared against act_in/batch_done by a negedge monitor.
module tb_sblk_act_feeder;

  localparam int LAT = 2;
  localparam int AW  = 12;
  localparam int DW  = 32;

  logic          clk_l;
  logic          rst_n;
  logic          inst_en;
  logic [20:0]   inst_data;
  logic          act_in_req;
  logic          act_in_vld;
  logic [DW-1:0] act_in;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          busy;
  logic          batch_done;
  logic [1:0]    err;

  sblk_act_feeder #(
    .N_TILE(4), .WID_ACT(16), .WID_INST_TN(4), .WID_INST_TP(5),
    .WID_MEMADDR(AW), .MEM_RD_LAT(LAT), .MAX_PEND(3)
  ) dut (
    .clk_l(clk_l), .rst_n(rst_n), .inst_en(inst_en), .inst_data(inst_data),
    .act_in_req(act_in_req), .act_in_vld(act_in_vld), .act_in(act_in),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .busy(busy), .batch_done(batch_done), .err(err)
  );

  initial clk_l = 1'b0;
  always #5 clk_l = ~clk_l;

  function automatic logic [DW-1:0] fn(input logic [AW-1:0] a);
    return {4'hA, a, 4'h5, ~a};
  endfunction

  // Memory with one register stage: captured by the DUT LAT edges after the read launch.
  logic [DW-1:0] mem_q;
  always @(posedge clk_l) if (mem_rd_en) mem_q <= fn(mem_rd_addr);
  assign mem_rd_data = mem_q;

  typedef struct { logic [DW-1:0] data; logic last; } exp_t;
  exp_t          sbq[$];
  int            errors = 0;
  int            checks = 0;
  int            exp_zero = 0;
  logic [AW-1:0] exp_base = '0;
  logic [AW-1:0] exp_cursor = '0;
  int            exp_blen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_batch();
    logic [AW-1:0] a;
    for (int i = 0; i < exp_blen; i++) begin
      a = exp_base + exp_cursor;
      sbq.push_back('{data: fn(a), last: (i == exp_blen - 1)});
      exp_cursor = exp_cursor + 1'b1;
    end
  endtask

  task automatic load_inst(input logic [3:0] tn, input logic [4:0] tp, input logic [11:0] base);
    inst_data = {base, tp, tn};
    inst_en   = 1'b1;
    @(negedge clk_l);
    inst_en   = 1'b0;
    inst_data = '0;
    exp_base   = base;
    exp_cursor = '0;
    exp_blen   = int'(tn) * int'(tp) * 4;
    repeat (2) @(negedge clk_l);
  endtask

  task automatic pulse_req();
    act_in_req = 1'b1;
    @(negedge clk_l);
    act_in_req = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n = 0;
    while ((busy || sbq.size() != 0 || exp_zero != 0) && n < limit) begin
      @(negedge clk_l);
      n++;
    end
    chk({tag, "_timeout"}, 64'(n >= limit), 64'(0));
    repeat (6) @(negedge clk_l);
    chk({tag, "_busy_after"}, 64'(busy), 64'(0));
    chk({tag, "_words_left"}, 64'(sbq.size()), 64'(0));
  endtask

  always @(negedge clk_l) begin
    if (rst_n) begin
      if (act_in_vld) begin
        checks++;
        assert (sbq.size() != 0) else begin
          errors++;
          $error("FAIL extra_word: observed act_in=%0h expected no word", act_in);
        end
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("act_in", 64'(act_in), 64'(e.data));
          chk("batch_done_on_word", 64'(batch_done), 64'(e.last));
        end
      end else if (batch_done) begin
        checks++;
        assert (exp_zero > 0) else begin
          errors++;
          $error("FAIL stray_batch_done: observed batch_done=1 expected 0");
        end
        if (exp_zero > 0) exp_zero--;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; inst_en = 1'b0; inst_data = '0; act_in_req = 1'b0;
    repeat (3) @(negedge clk_l);
    chk("rst_vld",   64'(act_in_vld), 64'(0));
    chk("rst_act",   64'(act_in), 64'(0));
    chk("rst_rd_en", 64'(mem_rd_en), 64'(0));
    chk("rst_addr",  64'(mem_rd_addr), 64'(0));
    chk("rst_busy",  64'(busy), 64'(0));
    chk("rst_done",  64'(batch_done), 64'(0));
    chk("rst_err",   64'(err), 64'(0));
    rst_n = 1'b1;
    @(negedge clk_l);

    // Basic batch and request-to-first-word latency
    load_inst(4'd2, 5'd3, 12'h100);
    chk("basic_idle_busy", 64'(busy), 64'(0));
    push_batch();
    act_in_req = 1'b1;
    @(negedge clk_l);
    act_in_req = 1'b0;
    chk("basic_first_addr", 64'(mem_rd_addr), 64'h100);
    chk("basic_busy", 64'(busy), 64'(1));
    n = 1;
    while (!act_in_vld && n < 10) begin
      @(negedge clk_l);
      n++;
    end
    chk("basic_latency", 64'(n), 64'(1 + LAT));
    wait_idle(200, "basic");

    // Back-to-back, plus a request landing on the DRAIN->STREAM start edge
    push_batch();
    pulse_req();
    repeat (5) @(negedge clk_l);
    push_batch();
    pulse_req();
    n = 0;
    while (!batch_done && n < 100) begin
      @(negedge clk_l);
      n++;
    end
    chk("b2b_done_timeout", 64'(n >= 100), 64'(0));
    push_batch();
    pulse_req();
    chk("b2b_next_start_addr", 64'(mem_rd_addr), 64'h130);
    chk("b2b_no_ovf", 64'(err[0]), 64'(0));
    wait_idle(400, "b2b");

    // Overflow: one running batch, four queued requests, three served
    push_batch();
    pulse_req();
    push_batch(); pulse_req();
    push_batch(); pulse_req();
    push_batch(); pulse_req();
    chk("ovf_err0_before", 64'(err[0]), 64'(0));
    pulse_req();
    chk("ovf_err0_set", 64'(err[0]), 64'(1));
    wait_idle(600, "ovf");

    // inst_en while busy is rejected and leaves the fields alone
    push_batch();
    pulse_req();
    repeat (3) @(negedge clk_l);
    inst_data = {12'h055, 5'd1, 4'd1};
    inst_en   = 1'b1;
    @(negedge clk_l);
    inst_en   = 1'b0;
    inst_data = '0;
    chk("rej_err1", 64'(err[1]), 64'(1));
    push_batch();
    pulse_req();
    wait_idle(300, "rej");
    chk("rej_err_both", 64'(err), 64'(3));

    // Zero-length batch
    load_inst(4'd0, 5'd3, 12'h200);
    exp_zero++;
    pulse_req();
    chk("zero_done", 64'(batch_done), 64'(1));
    chk("zero_busy", 64'(busy), 64'(0));
    chk("zero_rd_en", 64'(mem_rd_en), 64'(0));
    wait_idle(20, "zero");

    // Address wrap
    load_inst(4'd2, 5'd3, 12'hFF0);
    push_batch();
    pulse_req();
    wait_idle(200, "wrap");

    // Reset mid-burst
    push_batch();
    pulse_req();
    repeat (5) @(negedge clk_l);
    chk("mid_vld_before", 64'(act_in_vld), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",   64'(act_in_vld), 64'(0));
    chk("mid_rst_act",   64'(act_in), 64'(0));
    chk("mid_rst_rd_en", 64'(mem_rd_en), 64'(0));
    chk("mid_rst_addr",  64'(mem_rd_addr), 64'(0));
    chk("mid_rst_busy",  64'(busy), 64'(0));
    chk("mid_rst_done",  64'(batch_done), 64'(0));
    chk("mid_rst_err",   64'(err), 64'(0));
    sbq.delete();
    exp_zero = 0;
    @(negedge clk_l);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_l);
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_vld",  64'(act_in_vld), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
